// File: rtl/clearable_sram.sv
// Dual-port (2R/2W) byte-lane-masked SRAM
// with a sequential clear engine.
module clearable_sram #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter logic [D_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int INITIALIZE_FROM_FILE = 0,
  parameter FILE = "rom.mem",
  parameter int FILE_TYPE_BIN = 0,
  localparam int LANES = D_WIDTH / LANE_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_req,
  output logic               busy,
  input  logic               read_en_a,
  input  logic [A_WIDTH-1:0] read_addr_a,
  output logic [D_WIDTH-1:0] read_a,
  output logic               read_valid_a,
  input  logic               read_en_b,
  input  logic [A_WIDTH-1:0] read_addr_b,
  output logic [D_WIDTH-1:0] read_b,
  output logic               read_valid_b,
  input  logic               write_en_a,
  input  logic [A_WIDTH-1:0] write_addr_a,
  input  logic [LANES-1:0]   write_mask_a,
  input  logic [D_WIDTH-1:0] write_a,
  input  logic               write_en_b,
  input  logic [A_WIDTH-1:0] write_addr_b,
  input  logic [LANES-1:0]   write_mask_b,
  input  logic [D_WIDTH-1:0] write_b
);

  localparam int DEPTH = 2 ** A_WIDTH;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [A_WIDTH-1:0] r_cnt;
  logic [A_WIDTH-1:0] w_last;
  logic               w_busy;
  logic               w_clr_we;

  logic [D_WIDTH-1:0] r_mem [DEPTH];

  logic               w_rd_a;
  logic               w_rd_b;
  logic               w_wr_a;
  logic               w_wr_b;
  logic [D_WIDTH-1:0] w_rdata_a;
  logic [D_WIDTH-1:0] w_rdata_b;

  logic [D_WIDTH-1:0] r_read_a;
  logic [D_WIDTH-1:0] r_read_b;
  logic               r_valid_a;
  logic               r_valid_b;

  assign w_last = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ?
                 S_CLEAR : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_cnt == w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = rst_n;
      end
      default: begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + A_WIDTH'(1);
    end
  end

  assign busy = w_busy;

  assign w_rd_a = read_en_a  & ~w_busy;
  assign w_rd_b = read_en_b  & ~w_busy;
  assign w_wr_a = write_en_a & ~w_busy;
  assign w_wr_b = write_en_b & ~w_busy;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= CLEAR_VALUE;
    end else begin
      if (w_wr_b) begin
        for (int l = 0; l < LANES; l++) begin
          if (write_mask_b[l]) begin
            r_mem[write_addr_b]
              [l*LANE_WIDTH +: LANE_WIDTH] <=
              write_b[l*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
      if (w_wr_a) begin
        for (int l = 0; l < LANES; l++) begin
          if (write_mask_a[l]) begin
            r_mem[write_addr_a]
              [l*LANE_WIDTH +: LANE_WIDTH] <=
              write_a[l*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

`ifdef CLEARABLE_SRAM_BYPASS_EN
  function automatic logic [D_WIDTH-1:0] f_fwd(
    input logic [D_WIDTH-1:0] old_d,
    input logic [D_WIDTH-1:0] new_d,
    input logic [LANES-1:0]   mask,
    input logic               hit
  );
    logic [D_WIDTH-1:0] res;
    res = old_d;
    if (hit) begin
      for (int l = 0; l < LANES; l++) begin
        if (mask[l]) begin
          res[l*LANE_WIDTH +: LANE_WIDTH] =
            new_d[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rdata_a = f_fwd(r_mem[read_addr_a],
      write_a, write_mask_a,
      w_wr_a && (write_addr_a == read_addr_a));
    w_rdata_b = f_fwd(r_mem[read_addr_b],
      write_b, write_mask_b,
      w_wr_b && (write_addr_b == read_addr_b));
  end
`else
  always_comb begin
    w_rdata_a = r_mem[read_addr_a];
    w_rdata_b = r_mem[read_addr_b];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_a  <= '0;
      r_valid_a <= 1'b0;
    end else begin
      r_valid_a <= w_rd_a;
      if (w_rd_a) begin
        r_read_a <= w_rdata_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_b <= w_rd_b;
      if (w_rd_b) begin
        r_read_b <= w_rdata_b;
      end
    end
  end

  assign read_a       = r_read_a;
  assign read_b       = r_read_b;
  assign read_valid_a = r_valid_a;
  assign read_valid_b = r_valid_b;

endmodule

// File: tb/tb_clearable_sram.sv
// Scoreboard bench for clearable_sram: random and directed traffic checked
// against a word-array reference model with a clear countdown.
module tb_clearable_sram;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int LW    = 8;
   localparam int LN    = DW / LW;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear_req = 1'b0;
   logic          busy;
   logic          read_en_a = 1'b0, read_en_b = 1'b0;
   logic [AW-1:0] read_addr_a = '0, read_addr_b = '0;
   logic [DW-1:0] read_a, read_b;
   logic          read_valid_a, read_valid_b;
   logic          write_en_a = 1'b0, write_en_b = 1'b0;
   logic [AW-1:0] write_addr_a = '0, write_addr_b = '0;
   logic [LN-1:0] write_mask_a = '0, write_mask_b = '0;
   logic [DW-1:0] write_a = '0, write_b = '0;

   clearable_sram #(
      .D_WIDTH(DW), .A_WIDTH(AW), .LANE_WIDTH(LW),
      .CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy),
      .read_en_a(read_en_a), .read_addr_a(read_addr_a),
      .read_a(read_a), .read_valid_a(read_valid_a),
      .read_en_b(read_en_b), .read_addr_b(read_addr_b),
      .read_b(read_b), .read_valid_b(read_valid_b),
      .write_en_a(write_en_a), .write_addr_a(write_addr_a),
      .write_mask_a(write_mask_a), .write_a(write_a),
      .write_en_b(write_en_b), .write_addr_b(write_addr_b),
      .write_mask_b(write_mask_b), .write_b(write_b)
   );

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] mem_m [DEPTH];
   int            clr_left = 0;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   logic          exp_va = 1'b0, exp_vb = 1'b0;
   logic [DW-1:0] last_a = '0, last_b = '0;
   logic [DW-1:0] ea, eb;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d,
                                           input logic [DW-1:0] new_d,
                                           input logic [LN-1:0] m);
      logic [DW-1:0] r;
      r = old_d;
      for (int l = 0; l < LN; l++)
         if (m[l]) r[l*LW +: LW] = new_d[l*LW +: LW];
      return r;
   endfunction

   // Monitor: pops expected data whenever the DUT presents a valid read.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid_a", read_valid_a, exp_va);
         if (read_valid_a) begin
            if (qa.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL data_a: valid with no pending read at %0t", $time);
            end else begin
               ea = qa.pop_front();
               chk("data_a", read_a, ea);
               last_a = ea;
            end
         end else begin
            chk("hold_a", read_a, last_a);
         end
         chk("valid_b", read_valid_b, exp_vb);
         if (read_valid_b) begin
            if (qb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL data_b: valid with no pending read at %0t", $time);
            end else begin
               eb = qb.pop_front();
               chk("data_b", read_b, eb);
               last_b = eb;
            end
         end else begin
            chk("hold_b", read_b, last_b);
         end
      end
   end

   // One clock of stimulus: model the cycle, then let the edge happen.
   task automatic tick();
      logic va, vb;
      logic [DW-1:0] e;
      va = 1'b0;
      vb = 1'b0;
      chk("busy", busy, (clr_left > 0));
      if (clr_left > 0) begin
         clr_left--;
      end else begin
         if (read_en_a) begin
            e = mem_m[read_addr_a];
`ifdef CLEARABLE_SRAM_BYPASS_EN
            if (write_en_a && write_addr_a == read_addr_a)
               e = merge(e, write_a, write_mask_a);
`endif
            qa.push_back(e);
            va = 1'b1;
         end
         if (read_en_b) begin
            e = mem_m[read_addr_b];
`ifdef CLEARABLE_SRAM_BYPASS_EN
            if (write_en_b && write_addr_b == read_addr_b)
               e = merge(e, write_b, write_mask_b);
`endif
            qb.push_back(e);
            vb = 1'b1;
         end
         if (write_en_b)
            mem_m[write_addr_b] = merge(mem_m[write_addr_b], write_b, write_mask_b);
         if (write_en_a)
            mem_m[write_addr_a] = merge(mem_m[write_addr_a], write_a, write_mask_a);
         if (clear_req) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         end
      end
      @(posedge clk);
      exp_va = va;
      exp_vb = vb;
      #1;
      read_en_a  = 1'b0;
      read_en_b  = 1'b0;
      write_en_a = 1'b0;
      write_en_b = 1'b0;
      clear_req  = 1'b0;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_read_a", read_a, 0);
      chk("rst_read_b", read_b, 0);
      chk("rst_valid_a", read_valid_a, 0);
      chk("rst_valid_b", read_valid_b, 0);
      chk("rst_busy", busy, 1);
      qa.delete();
      qb.delete();
      exp_va = 1'b0;
      exp_vb = 1'b0;
      last_a = '0;
      last_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endtask

   task automatic wr_a(input int ad, input logic [DW-1:0] d,
                       input logic [LN-1:0] m);
      write_en_a = 1'b1; write_addr_a = AW'(ad); write_a = d; write_mask_a = m;
   endtask

   task automatic wr_b(input int ad, input logic [DW-1:0] d,
                       input logic [LN-1:0] m);
      write_en_b = 1'b1; write_addr_b = AW'(ad); write_b = d; write_mask_b = m;
   endtask

   task automatic rd_a(input int ad);
      read_en_a = 1'b1; read_addr_a = AW'(ad);
   endtask

   task automatic rd_b(input int ad);
      read_en_b = 1'b1; read_addr_b = AW'(ad);
   endtask

   task automatic read_all_zero(input string nm);
      for (int i = 0; i < DEPTH; i++) begin
         rd_a(i);
         rd_b(DEPTH - 1 - i);
         tick();
         chk(nm, read_a, 16'h0000);
      end
   endtask

   task automatic fill();
      for (int i = 0; i < DEPTH; i += 2) begin
         wr_a(i, DW'($urandom), 2'b11);
         wr_b(i + 1, DW'($urandom), 2'b11);
         tick();
      end
   endtask

   initial begin
      #2;
      do_reset();
      repeat (DEPTH + 1) tick();
      read_all_zero("init_zero");

      wr_a(3, 16'hABCD, 2'b01); tick();
      wr_a(3, 16'h12FF, 2'b10); tick();
      rd_a(3); tick();
      chk("lane_merge", read_a, 16'h12CD);

      wr_a(5, 16'h1111, 2'b11); wr_b(5, 16'h2222, 2'b10); tick();
      rd_b(5); tick();
      chk("a_wins_full", read_b, 16'h1111);
      wr_a(5, 16'h1111, 2'b01); wr_b(5, 16'h2222, 2'b10); tick();
      rd_a(5); tick();
      chk("a_wins_lanes", read_a, 16'h2211);

      wr_a(7, 16'h5555, 2'b11); tick();
      wr_a(7, 16'hAAAA, 2'b11); rd_a(7); rd_b(7); tick();
`ifdef CLEARABLE_SRAM_BYPASS_EN
      chk("same_port_fwd", read_a, 16'hAAAA);
`else
      chk("same_port_old", read_a, 16'h5555);
`endif
      chk("cross_port_old", read_b, 16'h5555);

      for (int c = 0; c < 400; c++) begin
         int span;
         span = ($urandom % 2 == 0) ? 3 : DEPTH - 1;
         read_en_a    = ($urandom % 2 == 0);
         read_addr_a  = AW'($urandom_range(0, span));
         read_en_b    = ($urandom % 2 == 0);
         read_addr_b  = AW'($urandom_range(0, span));
         write_en_a   = ($urandom % 3 == 0);
         write_addr_a = AW'($urandom_range(0, span));
         write_mask_a = LN'($urandom);
         write_a      = DW'($urandom);
         write_en_b   = ($urandom % 3 == 0);
         write_addr_b = AW'($urandom_range(0, span));
         write_mask_b = LN'($urandom);
         write_b      = DW'($urandom);
         clear_req    = ($urandom % 60 == 0);
         tick();
      end
      while (clr_left > 0) tick();

      fill();
      clear_req = 1'b1; tick();
      for (int c = 1; c <= DEPTH; c++) begin
         if (c == 4) begin
            wr_a(2, 16'hBEEF, 2'b11);
            clear_req = 1'b1;
         end
         tick();
      end
      chk("clear_done", busy, 0);
      read_all_zero("clear_zero");

      fill();
      clear_req = 1'b1; tick();
      repeat (8) tick();
      do_reset();
      repeat (DEPTH) tick();
      chk("rst_clear_done", busy, 0);
      read_all_zero("rst_clear_zero");

      repeat (3) tick();
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
